// File: rtl/demod_integ_pkg.sv
// Shared types and default widths for the demodulation integrator.
package demod_integ_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_CNT_W  = 10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DELAY     = 2'd1,
    INTEGRATE = 2'd2,
    DONE      = 2'd3
  } state_t;

endpackage

// File: rtl/demod_integrator_if.sv
// Lane stream in, integration results out, between demodulator front end and integrator.
interface demod_integrator_if import demod_integ_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) ();

  logic                     trigger_in;
  logic signed [DATA_W-1:0] data_i_0, data_i_1, data_i_2, data_i_3, data_i_4;
  logic signed [DATA_W-1:0] data_q_0, data_q_1, data_q_2, data_q_3, data_q_4;
  logic                     data_valid;
  logic signed [ACC_W-1:0]  sum_i;
  logic signed [ACC_W-1:0]  sum_q;
  logic                     result_valid;
  logic                     qubit_state;
  logic                     busy;
  logic                     trig_overrun;

  modport master (
    output trigger_in, data_valid,
    output data_i_0, data_i_1, data_i_2, data_i_3, data_i_4,
    output data_q_0, data_q_1, data_q_2, data_q_3, data_q_4,
    input  sum_i, sum_q, result_valid, qubit_state, busy, trig_overrun
  );

  modport slave (
    input  trigger_in, data_valid,
    input  data_i_0, data_i_1, data_i_2, data_i_3, data_i_4,
    input  data_q_0, data_q_1, data_q_2, data_q_3, data_q_4,
    output sum_i, sum_q, result_valid, qubit_state, busy, trig_overrun
  );

endinterface

// File: rtl/demod_integrator_lane_adder5.sv
// Combinational signed sum of five lanes; three guard bits make it overflow-free.
module lane_adder5 #(
  parameter int DATA_W = 16
) (
  input  logic signed [DATA_W-1:0] a0,
  input  logic signed [DATA_W-1:0] a1,
  input  logic signed [DATA_W-1:0] a2,
  input  logic signed [DATA_W-1:0] a3,
  input  logic signed [DATA_W-1:0] a4,
  output logic signed [DATA_W+2:0] sum
);

  assign sum = {{3{a0[DATA_W-1]}}, a0} + {{3{a1[DATA_W-1]}}, a1}
             + {{3{a2[DATA_W-1]}}, a2} + {{3{a3[DATA_W-1]}}, a3}
             + {{3{a4[DATA_W-1]}}, a4};

endmodule

// File: rtl/demod_integrator.sv
// Triggered I/Q window integrator with optional threshold discrimination.
// Optional feature macro: DEMOD_DISCRIM_EN (qubit_state comparator).
module demod_integrator import demod_integ_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  demod_integrator_if.slave       bus,
  input  logic [CNT_W-1:0]        cfg_delay,
  input  logic [CNT_W-1:0]        cfg_length,
  input  logic signed [ACC_W-1:0] cfg_threshold
);

  localparam int SUM_W = DATA_W + 3;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        delay_lat, length_lat;
  logic [CNT_W-1:0]        delay_cnt, beat_cnt;
  logic [CNT_W-1:0]        delay_cnt_inc, beat_cnt_inc;
  logic signed [ACC_W-1:0] acc_i, acc_q;
  logic signed [ACC_W-1:0] sum_i_reg, sum_q_reg;
  logic signed [SUM_W-1:0] lane_sum_i, lane_sum_q;
  logic                    result_valid_reg, trig_overrun_reg;
  logic                    start, accumulate;

  lane_adder5 #(.DATA_W(DATA_W)) u_add_i (
    .a0(bus.data_i_0), .a1(bus.data_i_1), .a2(bus.data_i_2),
    .a3(bus.data_i_3), .a4(bus.data_i_4), .sum(lane_sum_i)
  );

  lane_adder5 #(.DATA_W(DATA_W)) u_add_q (
    .a0(bus.data_q_0), .a1(bus.data_q_1), .a2(bus.data_q_2),
    .a3(bus.data_q_3), .a4(bus.data_q_4), .sum(lane_sum_q)
  );

  assign delay_cnt_inc = delay_cnt + 1'b1;
  assign beat_cnt_inc  = beat_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // The window ends on the edge that takes the final beat, so DONE is entered
  // together with that accumulation and the result registers one edge later.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    accumulate = 1'b0;
    case (state)
      IDLE: begin
        if (bus.trigger_in) begin
          start = 1'b1;
          if (cfg_delay != '0) state_next = DELAY;
          else                 state_next = INTEGRATE;
        end
      end
      DELAY: begin
        if (delay_cnt_inc == delay_lat) begin
          if (length_lat == '0) state_next = DONE;
          else                  state_next = INTEGRATE;
        end
      end
      INTEGRATE: begin
        if (length_lat == '0) begin
          state_next = DONE;
        end else if (bus.data_valid) begin
          accumulate = 1'b1;
          if (beat_cnt_inc == length_lat) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      delay_lat        <= '0;
      length_lat       <= '0;
      delay_cnt        <= '0;
      beat_cnt         <= '0;
      acc_i            <= '0;
      acc_q            <= '0;
      sum_i_reg        <= '0;
      sum_q_reg        <= '0;
      result_valid_reg <= 1'b0;
      trig_overrun_reg <= 1'b0;
    end else begin
      result_valid_reg <= 1'b0;
      trig_overrun_reg <= bus.trigger_in && (state != IDLE);
      if (start) begin
        delay_lat  <= cfg_delay;
        length_lat <= cfg_length;
        delay_cnt  <= '0;
        beat_cnt   <= '0;
        acc_i      <= '0;
        acc_q      <= '0;
      end
      if (state == DELAY) delay_cnt <= delay_cnt_inc;
      if (accumulate) begin
        acc_i    <= acc_i + {{(ACC_W-SUM_W){lane_sum_i[SUM_W-1]}}, lane_sum_i};
        acc_q    <= acc_q + {{(ACC_W-SUM_W){lane_sum_q[SUM_W-1]}}, lane_sum_q};
        beat_cnt <= beat_cnt_inc;
      end
      if (state == DONE) begin
        sum_i_reg        <= acc_i;
        sum_q_reg        <= acc_q;
        result_valid_reg <= 1'b1;
      end
    end
  end

`ifdef DEMOD_DISCRIM_EN
  logic signed [ACC_W-1:0] threshold_lat;
  logic                    qubit_state_reg;

  // Decision uses the accumulator value that is being published as sum_i.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      threshold_lat   <= '0;
      qubit_state_reg <= 1'b0;
    end else begin
      if (start)          threshold_lat   <= cfg_threshold;
      if (state == DONE)  qubit_state_reg <= (acc_i > threshold_lat);
    end
  end

  assign bus.qubit_state = qubit_state_reg;
`else
  logic unused_threshold;
  assign unused_threshold = ^cfg_threshold;
  assign bus.qubit_state  = 1'b0;
`endif

  assign bus.sum_i        = sum_i_reg;
  assign bus.sum_q        = sum_q_reg;
  assign bus.result_valid = result_valid_reg;
  assign bus.trig_overrun = trig_overrun_reg;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_demod_integrator.sv
// Randomized self-checking bench for demod_integrator against a window-level sum model.
module tb_demod_integrator;

  logic              clk;
  logic              rst;
  logic [9:0]        cfg_delay;
  logic [9:0]        cfg_length;
  logic signed [31:0] cfg_threshold;
  int                checks;
  int                fails;

  demod_integrator_if #(.DATA_W(16), .ACC_W(32)) bus ();

  demod_integrator #(.DATA_W(16), .ACC_W(32), .CNT_W(10)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .cfg_delay(cfg_delay),
    .cfg_length(cfg_length),
    .cfg_threshold(cfg_threshold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_lanes(input bit rnd, input logic signed [15:0] fi, input logic signed [15:0] fq,
                             output longint si, output longint sq);
    logic signed [15:0] li[5];
    logic signed [15:0] lq[5];
    si = 0;
    sq = 0;
    for (int n = 0; n < 5; n++) begin
      li[n] = rnd ? 16'($urandom) : fi;
      lq[n] = rnd ? 16'($urandom) : fq;
      si += longint'(li[n]);
      sq += longint'(lq[n]);
    end
    bus.data_i_0 = li[0]; bus.data_i_1 = li[1]; bus.data_i_2 = li[2];
    bus.data_i_3 = li[3]; bus.data_i_4 = li[4];
    bus.data_q_0 = lq[0]; bus.data_q_1 = lq[1]; bus.data_q_2 = lq[2];
    bus.data_q_3 = lq[3]; bus.data_q_4 = lq[4];
  endtask

  // Model: the first `delay` edges after the trigger edge are skipped, then the
  // first `len` valid beats are summed; the result appears one edge after the last.
  task automatic run_window(input string tag, input int delay, input int len, input bit rnd,
                            input logic signed [15:0] fi, input logic signed [15:0] fq,
                            input int valid_pct, input int gap_at, input int gap_len,
                            input int overrun_at, input longint thr);
    longint si, sq, exp_i, exp_q, got_i, got_q;
    int beats, last_edge, got_edge;
    bit v, exp_qs;
    exp_i = 0; exp_q = 0; beats = 0; last_edge = -1; got_edge = -1;
    cfg_delay     = 10'(delay);
    cfg_length    = 10'(len);
    cfg_threshold = 32'(thr);
    @(negedge clk);
    bus.trigger_in = 1'b1;
    bus.data_valid = 1'b0;
    @(negedge clk);
    bus.trigger_in = 1'b0;
    for (int k = 1; k <= delay + 4 * len + 20; k++) begin
      drive_lanes(rnd, fi, fq, si, sq);
      v = ($urandom_range(99) < valid_pct);
      if (k >= gap_at && k < gap_at + gap_len) v = 1'b0;
      bus.data_valid = v;
      bus.trigger_in = (k == overrun_at);
      if (k > delay && beats < len && v) begin
        exp_i += si;
        exp_q += sq;
        beats++;
        if (beats == len) last_edge = k;
      end
      @(negedge clk);
      if (k == overrun_at) begin
        checks++;
        if (bus.trig_overrun !== 1'b1) begin
          fails++;
          $display("[TB] FAIL %s overrun pulse: got %b, expected 1", tag, bus.trig_overrun);
        end
      end
      if (k == overrun_at + 1) begin
        checks++;
        if (bus.trig_overrun !== 1'b0) begin
          fails++;
          $display("[TB] FAIL %s overrun width: got %b, expected 0", tag, bus.trig_overrun);
        end
      end
      if (bus.result_valid === 1'b1) begin
        got_edge = k;
        break;
      end
    end
    bus.trigger_in = 1'b0;
    bus.data_valid = 1'b0;
    checks++;
    if (got_edge < 0) begin
      fails++;
      $display("[TB] FAIL %s timeout: got no result_valid, expected a pulse", tag);
    end else if (len > 0 && got_edge != last_edge + 1) begin
      fails++;
      $display("[TB] FAIL %s latency: got edge %0d, expected %0d", tag, got_edge, last_edge + 1);
    end
    got_i = longint'(bus.sum_i);
    got_q = longint'(bus.sum_q);
    checks++;
    if (got_i !== exp_i) begin
      fails++;
      $display("[TB] FAIL %s sum_i: got %0d, expected %0d", tag, got_i, exp_i);
    end
    checks++;
    if (got_q !== exp_q) begin
      fails++;
      $display("[TB] FAIL %s sum_q: got %0d, expected %0d", tag, got_q, exp_q);
    end
`ifdef DEMOD_DISCRIM_EN
    exp_qs = (exp_i > thr);
`else
    exp_qs = 1'b0;
`endif
    checks++;
    if (bus.qubit_state !== exp_qs) begin
      fails++;
      $display("[TB] FAIL %s qubit_state: got %b, expected %b", tag, bus.qubit_state, exp_qs);
    end
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b0 || bus.busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s pulse width: got rv=%b busy=%b, expected 0 0", tag, bus.result_valid, bus.busy);
    end
    repeat (3) begin
      drive_lanes(1'b1, 16'sd0, 16'sd0, si, sq);
      bus.data_valid = 1'b1;
      @(negedge clk);
    end
    bus.data_valid = 1'b0;
    checks++;
    if (longint'(bus.sum_i) !== exp_i || longint'(bus.sum_q) !== exp_q || bus.qubit_state !== exp_qs) begin
      fails++;
      $display("[TB] FAIL %s hold: got %0d/%0d/%b, expected %0d/%0d/%b", tag,
               bus.sum_i, bus.sum_q, bus.qubit_state, exp_i, exp_q, exp_qs);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (bus.sum_i !== 32'sd0 || bus.sum_q !== 32'sd0 || bus.result_valid !== 1'b0 ||
        bus.qubit_state !== 1'b0 || bus.busy !== 1'b0 || bus.trig_overrun !== 1'b0) begin
      fails++;
      $display("[TB] FAIL %s zero outputs: got si=%0d sq=%0d rv=%b qs=%b busy=%b ov=%b, expected all 0",
               tag, bus.sum_i, bus.sum_q, bus.result_valid, bus.qubit_state, bus.busy, bus.trig_overrun);
    end
  endtask

  task automatic test_reset();
    longint si, sq;
    rst = 1'b0;
    bus.trigger_in = 1'b0;
    bus.data_valid = 1'b0;
    cfg_delay = '0; cfg_length = '0; cfg_threshold = '0;
    drive_lanes(1'b0, 16'sd0, 16'sd0, si, sq);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("post_reset_idle");
  endtask

  task automatic test_basic();
    run_window("basic_thr49", 0, 10, 1'b0, 16'sd1, -16'sd2, 100, -1, 0, -1, 49);
    run_window("basic_thr50", 0, 10, 1'b0, 16'sd1, -16'sd2, 100, -1, 0, -1, 50);
  endtask

  task automatic test_gap();
    run_window("gap", 3, 4, 1'b1, 16'sd0, 16'sd0, 100, 5, 2, -1, 0);
  endtask

  task automatic test_max();
    run_window("max_len", 0, 1023, 1'b0, 16'sd32767, -16'sd32768, 100, -1, 0, -1, 0);
  endtask

  task automatic test_overrun();
    run_window("overrun", 2, 8, 1'b1, 16'sd0, 16'sd0, 100, -1, 0, 5, 0);
  endtask

  task automatic test_length_zero();
    run_window("len0_d0", 0, 0, 1'b1, 16'sd0, 16'sd0, 100, -1, 0, -1, -1);
    run_window("len0_d3", 3, 0, 1'b1, 16'sd0, 16'sd0, 100, -1, 0, -1, 5);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      run_window("random", int'($urandom_range(5)), int'($urandom_range(20, 1)), 1'b1,
                 16'sd0, 16'sd0, 70, -1, 0, -1, longint'($urandom_range(400)) - 200);
    end
  endtask

  task automatic test_back_to_back();
    longint si, sq;
    bit rv[5], bz[5], ov[5];
    bit seen;
    cfg_delay = 10'd0; cfg_length = 10'd2;
    drive_lanes(1'b0, 16'sd1, 16'sd1, si, sq);
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.trigger_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rv[k] = bus.result_valid; bz[k] = bus.busy; ov[k] = bus.trig_overrun;
    end
    bus.trigger_in = 1'b0;
    checks++;
    if (rv[3] !== 1'b1 || bz[3] !== 1'b0) begin
      fails++;
      $display("[TB] FAIL held_trig first result: got rv=%b busy=%b, expected 1 0", rv[3], bz[3]);
    end
    checks++;
    if (bz[4] !== 1'b1 || ov[4] !== 1'b0 || ov[1] !== 1'b1) begin
      fails++;
      $display("[TB] FAIL held_trig restart: got busy=%b ov4=%b ov1=%b, expected 1 0 1", bz[4], ov[4], ov[1]);
    end
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) seen = 1'b1;
    end
    bus.data_valid = 1'b0;
    checks++;
    if (!seen || bus.sum_i !== 32'sd10 || bus.sum_q !== 32'sd10) begin
      fails++;
      $display("[TB] FAIL held_trig second result: got seen=%b si=%0d sq=%0d, expected 1 10 10",
               seen, bus.sum_i, bus.sum_q);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    longint si, sq;
    cfg_delay = 10'd0; cfg_length = 10'd20;
    @(negedge clk);
    bus.trigger_in = 1'b1;
    bus.data_valid = 1'b1;
    @(negedge clk);
    bus.trigger_in = 1'b0;
    repeat (3) begin
      drive_lanes(1'b1, 16'sd0, 16'sd0, si, sq);
      @(negedge clk);
    end
    bus.trigger_in = 1'b1;
    @(negedge clk);
    bus.trigger_in = 1'b0;
    checks++;
    if (bus.trig_overrun !== 1'b1 || bus.busy !== 1'b1) begin
      fails++;
      $display("[TB] FAIL reset_mid pre: got ov=%b busy=%b, expected 1 1", bus.trig_overrun, bus.busy);
    end
    #2 rst = 1'b0;
    #1 check_all_zero("reset_mid_async");
    bus.data_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_window("after_reset", 1, 6, 1'b1, 16'sd0, 16'sd0, 80, -1, 0, -1, 0);
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    test_reset();
    test_basic();
    test_gap();
    test_overrun();
    test_length_zero();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_max();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
